// File: rtl/ad9837_spi_tx.sv
// AD9837 3-wire SPI loader: full init after reset, then rewrites FREQ0 whenever freq moves.
// One cycle from trigger to first fsync fall; words are 35*CLK_DIV cycles each; freq is never stalled.
module ad9837_spi_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [27:0] freq,
  output logic        sclk,
  output logic        sdata,
  output logic        fsync,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(2 * CLK_DIV + 1);
  localparam logic [CW-1:0] PH  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GP  = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {IDLE, LEAD, LOW, HIGH, GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic [1:0]    word_idx, word_idx_nxt;
  logic          init_pending, init_pending_nxt;
  logic [27:0]   sent, sent_nxt, shadow, shadow_nxt;
  logic          sclk_nxt, sdata_nxt, fsync_nxt, busy_nxt, done_nxt;
  logic [15:0]   cur_word, next_word, first_word;
  logic [1:0]    last_idx;

  // Word list is derived on the fly from the index; init_pending stays set for the whole init run.
  function automatic logic [15:0] word_of(input logic [1:0] idx, input logic init,
                                          input logic [27:0] sh);
    case (idx)
      2'd0:    word_of = init ? 16'h2100 : 16'h2000;
      2'd1:    word_of = {2'b01, sh[13:0]};
      2'd2:    word_of = {2'b01, sh[27:14]};
      default: word_of = 16'h2000;
    endcase
  endfunction

  assign cur_word   = word_of(word_idx, init_pending, shadow);
  assign next_word  = word_of(word_idx + 2'd1, init_pending, shadow);
  assign first_word = word_of(2'd0, init_pending, freq);
  assign last_idx   = init_pending ? 2'd3 : 2'd2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      word_idx     <= '0;
      init_pending <= 1'b1;
      sent         <= '0;
      shadow       <= '0;
      sclk         <= 1'b1;
      sdata        <= 1'b0;
      fsync        <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      bit_cnt      <= bit_cnt_nxt;
      word_idx     <= word_idx_nxt;
      init_pending <= init_pending_nxt;
      sent         <= sent_nxt;
      shadow       <= shadow_nxt;
      sclk         <= sclk_nxt;
      sdata        <= sdata_nxt;
      fsync        <= fsync_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    bit_cnt_nxt      = bit_cnt;
    word_idx_nxt     = word_idx;
    init_pending_nxt = init_pending;
    sent_nxt         = sent;
    shadow_nxt       = shadow;
    sclk_nxt         = sclk;
    sdata_nxt        = sdata;
    fsync_nxt        = fsync;
    busy_nxt         = busy;
    done_nxt         = 1'b0;
    case (state)
      IDLE: begin
        if (init_pending || (freq != sent)) begin
          shadow_nxt   = freq;
          word_idx_nxt = 2'd0;
          cnt_nxt      = PH;
          state_nxt    = LEAD;
          fsync_nxt    = 1'b0;
          sclk_nxt     = 1'b1;
          sdata_nxt    = first_word[15];
          busy_nxt     = 1'b1;
        end
      end
      LEAD: begin
        if (cnt != '0) cnt_nxt = cnt - ONE;
        else begin
          state_nxt   = LOW;
          cnt_nxt     = PH;
          bit_cnt_nxt = 4'd15;
          sclk_nxt    = 1'b0;
        end
      end
      LOW: begin
        if (cnt != '0) cnt_nxt = cnt - ONE;
        else begin
          state_nxt = HIGH;
          cnt_nxt   = PH;
          sclk_nxt  = 1'b1;
          // Next bit goes out on the rising edge so it settles a full phase before the fall.
          if (bit_cnt != 4'd0) sdata_nxt = cur_word[bit_cnt - 4'd1];
        end
      end
      HIGH: begin
        if (cnt != '0) cnt_nxt = cnt - ONE;
        else if (bit_cnt == 4'd0) begin
          state_nxt = GAP;
          cnt_nxt   = GP;
          fsync_nxt = 1'b1;
          sdata_nxt = 1'b0;
        end else begin
          state_nxt   = LOW;
          cnt_nxt     = PH;
          bit_cnt_nxt = bit_cnt - 4'd1;
          sclk_nxt    = 1'b0;
        end
      end
      GAP: begin
        if (cnt != '0) cnt_nxt = cnt - ONE;
        else if (word_idx == last_idx) begin
          state_nxt        = IDLE;
          done_nxt         = 1'b1;
          busy_nxt         = 1'b0;
          sent_nxt         = shadow;
          init_pending_nxt = 1'b0;
        end else begin
          state_nxt    = LEAD;
          word_idx_nxt = word_idx + 2'd1;
          cnt_nxt      = PH;
          fsync_nxt    = 1'b0;
          sdata_nxt    = next_word[15];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
